// File: rtl/peripheral_uart_fifo_gen_wb.sv
`default_nettype none
// ============================================================================
// Module      : peripheral_uart_fifo_gen_wb
// Description : Generic-depth first-word-fall-through UART FIFO for the TX
//               and RX paths. It has sticky overrun/underrun flags and a
//               trigger level. Optional character timeout is enabled by the
//               macro UART_FIFO_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module peripheral_uart_fifo_gen_wb #(
    parameter int FIFO_WIDTH     = 8,
    parameter int FIFO_DEPTH     = 16,
    parameter int PTR_W          = $clog2(FIFO_DEPTH),
    parameter int CNT_W          = $clog2(FIFO_DEPTH) + 1,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                  clk,
    input  logic                  wb_rst_ni,
    input  logic                  push,
    input  logic                  pop,
    input  logic [FIFO_WIDTH-1:0] data_in,
    input  logic                  fifo_reset,
    input  logic                  reset_status,
    input  logic [CNT_W-1:0]      trig_level,
    output logic [FIFO_WIDTH-1:0] data_out,
    output logic [CNT_W-1:0]      count,
    output logic                  empty,
    output logic                  full,
    output logic                  overrun,
    output logic                  underrun,
    output logic                  trig_hit,
    output logic                  timeout
);

    localparam logic [CNT_W-1:0] c_depth = CNT_W'(FIFO_DEPTH);

    logic [FIFO_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      r_top;
    logic [PTR_W-1:0]      r_bottom;
    logic [CNT_W-1:0]      r_count;
    logic                  r_overrun;
    logic                  r_underrun;

    logic w_empty;
    logic w_full;
    logic w_push_acc;
    logic w_pop_acc;

    assign w_empty    = (r_count == '0);
    assign w_full     = (r_count == c_depth);
    // A full FIFO still takes a push when the head leaves on the same edge.
    assign w_push_acc = push && (!w_full || pop);
    assign w_pop_acc  = pop && !w_empty;

    always_ff @(posedge clk) begin
        if (!wb_rst_ni || fifo_reset) begin
            r_top      <= '0;
            r_bottom   <= '0;
            r_count    <= '0;
            r_overrun  <= 1'b0;
            r_underrun <= 1'b0;
        end else begin
            if (w_push_acc) r_top    <= r_top + PTR_W'(1);
            if (w_pop_acc)  r_bottom <= r_bottom + PTR_W'(1);
            case ({w_push_acc, w_pop_acc})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
            if (push && !pop && w_full) r_overrun <= 1'b1;
            else if (reset_status)      r_overrun <= 1'b0;
            if (pop && w_empty)         r_underrun <= 1'b1;
            else if (reset_status)      r_underrun <= 1'b0;
        end
    end

    // Storage is not reset; only the write is gated by both reset sources.
    always_ff @(posedge clk) begin
        if (wb_rst_ni && !fifo_reset && w_push_acc) r_mem[r_top] <= data_in;
    end

    assign data_out = r_mem[r_bottom];
    assign count    = r_count;
    assign empty    = w_empty;
    assign full     = w_full;
    assign overrun  = r_overrun;
    assign underrun = r_underrun;
    assign trig_hit = (trig_level != '0) && (r_count >= trig_level);

`ifdef UART_FIFO_TIMEOUT_EN
    localparam int               c_to_w   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_to_w-1:0] c_to_max = c_to_w'(TIMEOUT_CYCLES);

    logic [c_to_w-1:0] r_idle;
    logic [c_to_w-1:0] w_idle_nxt;
    logic              r_timeout;

    always_comb begin
        w_idle_nxt = r_idle;
        if (w_push_acc || w_pop_acc || w_empty) w_idle_nxt = '0;
        else if (r_idle != c_to_max)            w_idle_nxt = r_idle + c_to_w'(1);
    end

    always_ff @(posedge clk) begin
        if (!wb_rst_ni || fifo_reset) begin
            r_idle    <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_idle    <= w_idle_nxt;
            r_timeout <= (w_idle_nxt == c_to_max);
        end
    end

    assign timeout = r_timeout;
`else
    // Constant low; the parameter stays referenced so both builds share one interface.
    assign timeout = (TIMEOUT_CYCLES < 0);
`endif

endmodule
`default_nettype wire

// File: tb/tb_peripheral_uart_fifo_gen_wb.sv
`default_nettype none
// ============================================================================
// Module      : tb_peripheral_uart_fifo_gen_wb
// Description : Scoreboard bench for the generic UART FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_peripheral_uart_fifo_gen_wb;

    localparam int c_w   = 8;
    localparam int c_d   = 16;
    localparam int c_cw  = 5;
    localparam int c_to  = 64;

    logic            clk = 1'b0;
    logic            wb_rst_ni;
    logic            push;
    logic            pop;
    logic [c_w-1:0]  data_in;
    logic            fifo_reset;
    logic            reset_status;
    logic [c_cw-1:0] trig_level;
    logic [c_w-1:0]  data_out;
    logic [c_cw-1:0] count;
    logic            empty;
    logic            full;
    logic            overrun;
    logic            underrun;
    logic            trig_hit;
    logic            timeout;

    int       n_cmp = 0;
    int       n_bad = 0;
    bit       sb_en = 1'b0;
    logic [7:0] exp_q [$];

    peripheral_uart_fifo_gen_wb #(
        .FIFO_WIDTH    (c_w),
        .FIFO_DEPTH    (c_d),
        .TIMEOUT_CYCLES(c_to)
    ) dut (
        .clk         (clk),
        .wb_rst_ni   (wb_rst_ni),
        .push        (push),
        .pop         (pop),
        .data_in     (data_in),
        .fifo_reset  (fifo_reset),
        .reset_status(reset_status),
        .trig_level  (trig_level),
        .data_out    (data_out),
        .count       (count),
        .empty       (empty),
        .full        (full),
        .overrun     (overrun),
        .underrun    (underrun),
        .trig_hit    (trig_hit),
        .timeout     (timeout)
    );

    always #5 clk = ~clk;

    // Monitor: whenever the DUT hands out its head word, check it against the scoreboard.
    always @(negedge clk) begin
        if (sb_en && wb_rst_ni && !fifo_reset && pop && !empty) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL pop_unexpected: got data_out=%02h, required no output", data_out);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                if (data_out !== e) begin
                    n_bad++;
                    $display("FAIL pop_data: got %02h, required %02h", data_out, e);
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, required %0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One cycle of stimulus; acc queues the word as an expected future output.
    task automatic op(input logic p, input logic q, input logic [7:0] d, input logic acc);
        if (acc) exp_q.push_back(d);
        push    = p;
        pop     = q;
        data_in = d;
        tick();
        push    = 1'b0;
        pop     = 1'b0;
    endtask

    task automatic pulse_status();
        reset_status = 1'b1;
        tick();
        reset_status = 1'b0;
    endtask

    task automatic flush();
        fifo_reset = 1'b1;
        tick();
        fifo_reset = 1'b0;
        exp_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        wb_rst_ni    = 1'b0;
        push         = 1'b0;
        pop          = 1'b0;
        data_in      = '0;
        fifo_reset   = 1'b0;
        reset_status = 1'b0;
        trig_level   = '0;
        tick();
        tick();
        wb_rst_ni = 1'b1;

        // Random traffic, then a 2-cycle reset.
        for (int i = 0; i < 30; i++) begin
            push    = 1'($urandom_range(0, 1));
            pop     = 1'($urandom_range(0, 1));
            data_in = 8'($urandom);
            tick();
        end
        push = 1'b0;
        pop  = 1'b0;
        wb_rst_ni = 1'b0;
        tick();
        tick();
        wb_rst_ni = 1'b1;
        chk("rst_count", count, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_underrun", underrun, 0);
        chk("rst_timeout", timeout, 0);
        chk("rst_trig_hit", trig_hit, 0);
        exp_q.delete();
        sb_en = 1'b1;

        // Fill, overflow, drain in order.
        for (int i = 0; i < 16; i++) op(1'b1, 1'b0, 8'(i), 1'b1);
        chk("fill_count", count, 16);
        chk("fill_full", full, 1);
        chk("fill_overrun", overrun, 0);
        op(1'b1, 1'b0, 8'hAA, 1'b0);
        chk("ovf_count", count, 16);
        chk("ovf_full", full, 1);
        chk("ovf_overrun", overrun, 1);
        for (int i = 0; i < 16; i++) op(1'b0, 1'b1, 8'h00, 1'b0);
        chk("drain_empty", empty, 1);
        chk("drain_count", count, 0);
        chk("drain_sb_left", exp_q.size(), 0);
        chk("drain_overrun_sticky", overrun, 1);
        chk("drain_underrun", underrun, 0);
        pulse_status();
        chk("status_clr_overrun", overrun, 0);

        // Simultaneous push/pop on empty and on full.
        op(1'b1, 1'b1, 8'h5A, 1'b1);
        chk("pp_empty_count", count, 1);
        chk("pp_empty_data", data_out, 8'h5A);
        chk("pp_empty_underrun", underrun, 1);
        pulse_status();
        chk("status_clr_underrun", underrun, 0);
        for (int i = 0; i < 15; i++) op(1'b1, 1'b0, 8'(8'h10 + i), 1'b1);
        chk("pp_full_pre", count, 16);
        op(1'b1, 1'b1, 8'hC3, 1'b1);
        chk("pp_full_count", count, 16);
        chk("pp_full_full", full, 1);
        chk("pp_full_overrun", overrun, 0);
        chk("pp_full_head", data_out, 8'h10);
        op(1'b1, 1'b0, 8'hEE, 1'b0);
        chk("ovf2_overrun", overrun, 1);
        fifo_reset = 1'b1;
        push       = 1'b1;
        data_in    = 8'h77;
        tick();
        fifo_reset = 1'b0;
        push       = 1'b0;
        exp_q.delete();
        chk("flush_count", count, 0);
        chk("flush_empty", empty, 1);
        chk("flush_overrun", overrun, 0);

        // Set wins over a coincident reset_status.
        reset_status = 1'b1;
        op(1'b0, 1'b1, 8'h00, 1'b0);
        reset_status = 1'b0;
        chk("set_wins_underrun", underrun, 1);
        pulse_status();
        chk("status_clr2", underrun, 0);

        // Wrap-around with occupancy held at 3.
        for (int i = 0; i < 3; i++) op(1'b1, 1'b0, 8'(8'h20 + i), 1'b1);
        for (int i = 0; i < 40; i++) begin
            op(1'b1, 1'b1, 8'(8'h30 + i), 1'b1);
            chk("wrap_count", count, 3);
        end
        for (int i = 0; i < 3; i++) op(1'b0, 1'b1, 8'h00, 1'b0);
        chk("wrap_empty", empty, 1);
        chk("wrap_sb_left", exp_q.size(), 0);
        chk("wrap_underrun", underrun, 0);

        // Trigger level.
        trig_level = 5'd8;
        for (int i = 0; i < 7; i++) op(1'b1, 1'b0, 8'(8'h40 + i), 1'b1);
        chk("trig_7", trig_hit, 0);
        op(1'b1, 1'b0, 8'h47, 1'b1);
        chk("trig_8", trig_hit, 1);
        for (int i = 8; i < 16; i++) op(1'b1, 1'b0, 8'(8'h40 + i), 1'b1);
        trig_level = 5'd0;
        #1;
        chk("trig_disabled_full", trig_hit, 0);
        trig_level = 5'd16;
        #1;
        chk("trig_16_full", trig_hit, 1);
        trig_level = 5'd0;
        flush();

        // Character timeout.
        op(1'b1, 1'b0, 8'h99, 1'b1);
`ifdef UART_FIFO_TIMEOUT_EN
        for (int k = 1; k <= 64; k++) begin
            tick();
            chk("timeout_idle", timeout, (k == 64) ? 1 : 0);
        end
        tick();
        chk("timeout_hold", timeout, 1);
        op(1'b0, 1'b1, 8'h00, 1'b0);
        chk("timeout_pop_clr", timeout, 0);
        chk("timeout_pop_empty", empty, 1);
`else
        for (int k = 1; k <= 70; k++) begin
            tick();
            chk("timeout_off", timeout, 0);
        end
        op(1'b0, 1'b1, 8'h00, 1'b0);
        chk("timeout_off_empty", empty, 1);
`endif
        chk("end_sb_left", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
